// File: rtl/glyph_matcher_pkg.sv
// Shared constants for the serial 4x7 glyph recognizer: geometry, the
// ordered candidate table and the controller state encoding.
package glyph_pkg;

   localparam int GLYPH_W     = 4;
   localparam int GLYPH_H     = 7;
   localparam int GLYPH_PIX   = 28;
   localparam int GLYPH_COUNT = 31;

   // Search order matters: digits precede 'S' and 'O' so identical bitmaps decode as digits.
   localparam logic [7:0] GLYPH_TABLE [0:GLYPH_COUNT-1] = '{
      8'h20,
      8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
      8'h53, 8'h43, 8'h4F, 8'h52, 8'h45, 8'h3A,
      8'h50, 8'h4C, 8'h41, 8'h59,
      8'h51, 8'h55, 8'h49, 8'h54,
      8'h47, 8'h46,
      8'h42, 8'h4B,
      8'h48, 8'h4D
   };

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SEARCH  = 2'd1,
      DONE    = 2'd2
   } state_t;

endpackage

// File: rtl/font4x7.sv
// 4x7 font ROM, one pixel per lookup. Glyph rows are packed top row first,
// leftmost pixel in the MSB of each 4-bit row.
module font4x7 (
   input  logic [7:0] code,
   input  logic [2:0] y,
   input  logic [1:0] x,
   output logic       pix
);

   logic [27:0] glyph;
   logic [4:0]  n;

   always_comb begin
      glyph = 28'h0000000;
      case (code)
         8'h20: glyph = 28'h0000000;
         8'h30: glyph = 28'hF99999F;
         8'h31: glyph = 28'h2622227;
         8'h32: glyph = 28'hF11F88F;
         8'h33: glyph = 28'hF11711F;
         8'h34: glyph = 28'h999F111;
         8'h35: glyph = 28'hF88F11F;
         8'h36: glyph = 28'hF88F99F;
         8'h37: glyph = 28'hF112444;
         8'h38: glyph = 28'hF99F99F;
         8'h39: glyph = 28'hF99F11F;
         8'h3A: glyph = 28'h0660660;
         8'h41: glyph = 28'h699F999;
         8'h42: glyph = 28'hE99E99E;
         8'h43: glyph = 28'hF88888F;
         8'h45: glyph = 28'hF88E88F;
         8'h46: glyph = 28'hF88E888;
         8'h47: glyph = 28'h788B997;
         8'h48: glyph = 28'h999F999;
         8'h49: glyph = 28'h7222227;
         8'h4B: glyph = 28'h9AC8CA9;
         8'h4C: glyph = 28'h888888F;
         8'h4D: glyph = 28'h9FF9999;
         8'h4F: glyph = 28'hF99999F;
         8'h50: glyph = 28'hE99E888;
         8'h51: glyph = 28'h6999B61;
         8'h52: glyph = 28'hE99EA99;
         8'h53: glyph = 28'hF88F11F;
         8'h54: glyph = 28'hE444444;
         8'h55: glyph = 28'h9999996;
         8'h59: glyph = 28'h9996222;
         default: glyph = 28'h0000000;
      endcase
   end

   // {y, x} is the raster index y*4 + x; row 7 lies outside the cell.
   assign n   = {y, x};
   assign pix = (n <= 5'd27) ? glyph[5'd27 - n] : 1'b0;

endmodule

// File: rtl/glyph_matcher.sv
// Captures a 28-pixel 4x7 bitmap serially, then scans the candidate table one
// font row per cycle and reports the first matching ASCII code.
module glyph_matcher
   import glyph_pkg::*;
#(
   parameter logic [7:0] NOMATCH_CHAR = 8'h3F
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       pix_valid,
   input  logic       pix_bit,
   output logic       pix_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_char,
   output logic       out_match,
   output logic       busy,
   output state_t     state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high; valid never depends on ready, and results hold until taken.

   logic [3:0] rows [0:GLYPH_H-1];
   logic [4:0] count;
   logic [4:0] cand;
   logic [2:0] row;
   logic       row_ok;
   logic [3:0] font_row;
   logic       row_match;

   assign pix_ready = (state == COLLECT) && !flush;
   assign row_match = row_ok && (rows[row] == font_row);

   for (genvar xi = 0; xi < GLYPH_W; xi++) begin : g_font
      font4x7 u_font (
         .code (GLYPH_TABLE[cand]),
         .y    (row),
         .x    (2'(xi)),
         .pix  (font_row[GLYPH_W-1-xi])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= COLLECT;
         count     <= 5'd0;
         cand      <= 5'd0;
         row       <= 3'd0;
         row_ok    <= 1'b1;
         out_valid <= 1'b0;
         out_char  <= 8'h00;
         out_match <= 1'b0;
         busy      <= 1'b0;
         for (int i = 0; i < GLYPH_H; i++) rows[i] <= 4'h0;
      end else begin
         case (state)
            COLLECT: begin
               if (flush) begin
                  count <= 5'd0;
               end else if (pix_valid) begin
                  // Pixel n lands in row n/4, bit 3 - n%4.
                  rows[count[4:2]][~count[1:0]] <= pix_bit;
                  if (count == 5'(GLYPH_PIX - 1)) begin
                     state  <= SEARCH;
                     count  <= 5'd0;
                     cand   <= 5'd0;
                     row    <= 3'd0;
                     row_ok <= 1'b1;
                     busy   <= 1'b1;
                  end else begin
                     count <= count + 5'd1;
                  end
               end
            end
            SEARCH: begin
               if (flush) begin
                  state <= COLLECT;
                  count <= 5'd0;
                  busy  <= 1'b0;
               end else if (row == 3'(GLYPH_H - 1)) begin
                  if (row_match) begin
                     state     <= DONE;
                     busy      <= 1'b0;
                     out_valid <= 1'b1;
                     out_char  <= GLYPH_TABLE[cand];
                     out_match <= 1'b1;
                  end else if (cand == 5'(GLYPH_COUNT - 1)) begin
                     state     <= DONE;
                     busy      <= 1'b0;
                     out_valid <= 1'b1;
                     out_char  <= NOMATCH_CHAR;
                     out_match <= 1'b0;
                  end else begin
                     cand   <= cand + 5'd1;
                     row    <= 3'd0;
                     row_ok <= 1'b1;
                  end
               end else begin
                  row    <= row + 3'd1;
                  row_ok <= row_match;
               end
            end
            DONE: begin
               if (out_ready || flush) begin
                  state     <= COLLECT;
                  count     <= 5'd0;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state <= COLLECT;
               count <= 5'd0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_glyph_matcher.sv
// Bench for glyph_matcher: directed and randomized bitmaps compared against a
// first-match table model with latency 7*(k+1) cycles.
module tb_glyph_matcher;
   import glyph_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       pix_valid = 1'b0;
   logic       pix_bit = 1'b0;
   logic       pix_ready;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_char;
   logic       out_match;
   logic       busy;
   state_t     dut_state;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [7:0] CHARS [0:30] = '{
      8'h20, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
      8'h39, 8'h53, 8'h43, 8'h4F, 8'h52, 8'h45, 8'h3A, 8'h50, 8'h4C, 8'h41,
      8'h59, 8'h51, 8'h55, 8'h49, 8'h54, 8'h47, 8'h46, 8'h42, 8'h4B, 8'h48,
      8'h4D
   };
   localparam logic [27:0] GLYPHS [0:30] = '{
      28'h0000000, 28'hF99999F, 28'h2622227, 28'hF11F88F, 28'hF11711F,
      28'h999F111, 28'hF88F11F, 28'hF88F99F, 28'hF112444, 28'hF99F99F,
      28'hF99F11F, 28'hF88F11F, 28'hF88888F, 28'hF99999F, 28'hE99EA99,
      28'hF88E88F, 28'h0660660, 28'hE99E888, 28'h888888F, 28'h699F999,
      28'h9996222, 28'h6999B61, 28'h9999996, 28'h7222227, 28'hE444444,
      28'h788B997, 28'hF88E888, 28'hE99E99E, 28'h9AC8CA9, 28'h999F999,
      28'h9FF9999
   };

   glyph_matcher #(.NOMATCH_CHAR(8'h3F)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .pix_valid (pix_valid),
      .pix_bit   (pix_bit),
      .pix_ready (pix_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_char  (out_char),
      .out_match (out_match),
      .busy      (busy),
      .state     (dut_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [27:0] bm, output logic [7:0] ch,
                                 output logic m, output int lat);
      bit found = 1'b0;
      ch  = 8'h3F;
      m   = 1'b0;
      lat = 7 * 31;
      for (int k = 0; k < 31; k++) begin
         if (!found && bm == GLYPHS[k]) begin
            found = 1'b1;
            ch    = CHARS[k];
            m     = 1'b1;
            lat   = 7 * (k + 1);
         end
      end
   endfunction

   // Feeds pixels first..last of bm with random idle gaps; returns just after the last accept edge.
   task automatic send_pixels(input logic [27:0] bm, input int first, input int last);
      for (int n = first; n <= last; n++) begin
         int gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(negedge clk);
            pix_valid = 1'b0;
         end
         @(negedge clk);
         pix_valid = 1'b1;
         pix_bit   = bm[27-n];
         @(posedge clk);
      end
      #1;
      pix_valid = 1'b0;
   endtask

   // Counts edges after the accept edge until out_valid; an expired budget is a failure.
   task automatic wait_result(input string tag, output int lat);
      lat = 0;
      while (lat < 300) begin
         @(posedge clk);
         lat++;
         #1;
         if (out_valid) break;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic handshake(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      check({tag, "_valid_before_take"}, 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_valid_after_take"}, 32'(out_valid), 32'd0);
      check({tag, "_ready_after_take"}, 32'(pix_ready), 32'd1);
   endtask

   task automatic run_case(input string tag, input logic [27:0] bm);
      logic [7:0] exp_ch;
      logic       exp_m;
      int         exp_lat;
      int         lat;
      model(bm, exp_ch, exp_m, exp_lat);
      send_pixels(bm, 0, 27);
      wait_result(tag, lat);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_char"}, 32'(out_char), 32'(exp_ch));
      check({tag, "_match"}, 32'(out_match), 32'(exp_m));
      if (lat > 0) handshake(tag);
   endtask

   initial begin
      logic [27:0] bm;
      logic [7:0]  exp_ch;
      logic        exp_m;
      int          exp_lat;
      int          lat;
      int          seen;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_char", 32'(out_char), 32'h00);
      check("rst_out_match", 32'(out_match), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pix_ready", 32'(pix_ready), 32'd1);

      // Directed glyphs and boundary bitmaps
      run_case("digit1", 28'h2622227);
      run_case("letter_o", 28'hF99999F);
      run_case("letter_s", 28'hF88F11F);
      run_case("all_zero", 28'h0000000);
      run_case("all_one", 28'hFFFFFFF);
      run_case("letter_m", 28'h9FF9999);

      // Backpressure: result held, pixels refused
      bm = 28'h999F111;
      model(bm, exp_ch, exp_m, exp_lat);
      send_pixels(bm, 0, 27);
      wait_result("bp", lat);
      check("bp_latency", 32'(lat), 32'(exp_lat));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         pix_valid = 1'b1;
         pix_bit   = 1'($urandom_range(0, 1));
         #1;
         check("bp_pix_ready", 32'(pix_ready), 32'd0);
         check("bp_valid_held", 32'(out_valid), 32'd1);
         check("bp_char_held", 32'(out_char), 32'(exp_ch));
         check("bp_match_held", 32'(out_match), 32'(exp_m));
      end
      @(negedge clk);
      pix_valid = 1'b0;
      handshake("bp");
      run_case("after_bp", 28'hF11F88F);

      // Flush mid-collect drops the partial bitmap
      send_pixels(28'hFFFFFFF, 0, 12);
      @(negedge clk);
      flush     = 1'b1;
      pix_valid = 1'b1;
      pix_bit   = 1'b1;
      #1;
      check("flush_collect_ready", 32'(pix_ready), 32'd0);
      @(posedge clk);
      #1;
      flush     = 1'b0;
      pix_valid = 1'b0;
      run_case("after_flush_7", 28'hF112444);

      // Flush during search abandons it
      send_pixels(28'hFFFFFFF, 0, 27);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("flush_search_busy", 32'(busy), 32'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_search_state", 32'(dut_state), 32'(COLLECT));
      check("flush_search_busy_low", 32'(busy), 32'd0);
      seen = 0;
      repeat (230) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("flush_search_no_result", 32'(seen), 32'd0);
      run_case("after_flush_zero", 28'h0000000);

      // Reset mid-search
      send_pixels(28'hFFFFFFF, 0, 27);
      repeat (30) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_char", 32'(out_char), 32'h00);
      check("midrst_out_match", 32'(out_match), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrst_pix_ready", 32'(pix_ready), 32'd1);
      run_case("after_rst_9", 28'hF99F11F);

      // Randomized: table glyphs, single-pixel corruptions and raw noise
      for (int it = 0; it < 14; it++) begin
         int sel = $urandom_range(0, 3);
         bm = GLYPHS[$urandom_range(0, 30)];
         if (sel == 0) bm = 28'($urandom);
         else if (sel == 1) bm = bm ^ (28'd1 << $urandom_range(0, 27));
         run_case($sformatf("rand%0d", it), bm);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
